// File: rtl/i2c_slave_regbank.sv
// i2c_slave_regbank: I2C target with a small byte register bank.
// Master writes fill the bank sequentially and master reads stream it back.
// scl/sda are oversampled on clk. sda is only ever pulled low (open drain),
// and scl is never driven, so there is no clock stretching.
// Optional macro I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter
// on both lines after the synchronizers.
module i2c_slave_regbank #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         NUM_REGS    = 5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  inout  wire                   sda,
  output logic [8*NUM_REGS-1:0] reg_q,
  output logic                  wr_valid,
  output logic [3:0]            wr_idx,
  output logic                  addr_hit,
  output logic                  busy
);

  localparam int PW = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_s, sda_s;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_rise, scl_fall, sda_rise, sda_fall;
  logic                   start_c, stop_c;

  state_t          state_q;
  logic [2:0]      bit_cnt_q;
  logic [6:0]      shift_q;
  logic [7:0]      shift_d;
  logic [6:0]      tx_q;
  logic [PW-1:0]   ptr_q, ptr_inc;
  logic            done_q, rw_q;
  logic            sda_oe_q, busy_q, wr_valid_q, addr_hit_q;
  logic [3:0]      wr_idx_q;
  logic [7:0]      bank_q [NUM_REGS];

  // Input synchronizers. They carry no reset so they keep tracking the bus
  // while rst is high; this keeps a reset in the middle of a high scl phase
  // from manufacturing a false START/STOP edge when rst is released.
  always_ff @(posedge clk) begin
    scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
    sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [2:0] scl_flt_q, sda_flt_q;

  // Three-sample history per line; majority vote hides single-clk glitches.
  always_ff @(posedge clk) begin
    scl_flt_q <= {scl_flt_q[1:0], scl_sync_q[SYNC_STAGES-1]};
    sda_flt_q <= {sda_flt_q[1:0], sda_sync_q[SYNC_STAGES-1]};
  end

  assign scl_s = (scl_flt_q[0] & scl_flt_q[1]) | (scl_flt_q[0] & scl_flt_q[2]) |
                 (scl_flt_q[1] & scl_flt_q[2]);
  assign sda_s = (sda_flt_q[0] & sda_flt_q[1]) | (sda_flt_q[0] & sda_flt_q[2]) |
                 (sda_flt_q[1] & sda_flt_q[2]);
`else
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
`endif

  // One-clk delayed copies of the cleaned lines for edge detection.
  always_ff @(posedge clk) begin
    scl_prev_q <= scl_s;
    sda_prev_q <= sda_s;
  end

  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign sda_rise = sda_s & ~sda_prev_q;
  assign sda_fall = ~sda_s & sda_prev_q;
  // sda moving while scl is high is bus framing, never data.
  assign start_c  = sda_fall & scl_s;
  assign stop_c   = sda_rise & scl_s;

  assign shift_d = {shift_q, sda_s};
  assign ptr_inc = (ptr_q == PW'(NUM_REGS - 1)) ? '0 : ptr_q + PW'(1);

  // Protocol FSM: START/STOP override every state; data is sampled on scl
  // rise and sda_oe only ever changes on scl fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd7;
      shift_q    <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      done_q     <= 1'b0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      addr_hit_q <= 1'b0;
      wr_idx_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= '0;
    end else begin
      wr_valid_q <= 1'b0;
      addr_hit_q <= 1'b0;
      if (start_c) begin
        state_q   <= S_ADDR;
        bit_cnt_q <= 3'd7;
        ptr_q     <= '0;
        done_q    <= 1'b0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b1;
      end else if (stop_c) begin
        state_q  <= S_IDLE;
        done_q   <= 1'b0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          S_ADDR: begin
            if (scl_rise) begin
              shift_q <= shift_d[6:0];
              if (bit_cnt_q == 3'd0) begin
                if (shift_d[7:1] == SLAVE_ADDR) begin
                  done_q <= 1'b1;
                  rw_q   <= shift_d[0];
                end else begin
                  state_q <= S_WAIT_STOP;
                  busy_q  <= 1'b0;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q - 3'd1;
              end
            end else if (scl_fall && done_q) begin
              done_q     <= 1'b0;
              sda_oe_q   <= 1'b1;
              addr_hit_q <= 1'b1;
              state_q    <= S_ADDR_ACK;
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt_q <= 3'd7;
              if (rw_q) begin
                tx_q     <= bank_q[ptr_q][6:0];
                sda_oe_q <= ~bank_q[ptr_q][7];
                state_q  <= S_RD_BYTE;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= S_WR_BYTE;
              end
            end
          end
          S_WR_BYTE: begin
            if (scl_rise) begin
              shift_q <= shift_d[6:0];
              if (bit_cnt_q == 3'd0) begin
                bank_q[ptr_q] <= shift_d;
                wr_valid_q    <= 1'b1;
                wr_idx_q      <= 4'(ptr_q);
                ptr_q         <= ptr_inc;
                done_q        <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q - 3'd1;
              end
            end else if (scl_fall && done_q) begin
              done_q   <= 1'b0;
              sda_oe_q <= 1'b1;
              state_q  <= S_WR_ACK;
            end
          end
          S_WR_ACK: begin
            if (scl_fall) begin
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= 3'd7;
              state_q   <= S_WR_BYTE;
            end
          end
          S_RD_BYTE: begin
            if (scl_fall) begin
              if (bit_cnt_q == 3'd0) begin
                sda_oe_q <= 1'b0;
                state_q  <= S_RD_ACK;
              end else begin
                sda_oe_q  <= ~tx_q[6];
                tx_q      <= {tx_q[5:0], 1'b0};
                bit_cnt_q <= bit_cnt_q - 3'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                ptr_q  <= ptr_inc;
                done_q <= 1'b1;
              end else begin
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
                state_q  <= S_WAIT_STOP;
              end
            end else if (scl_fall && done_q) begin
              done_q    <= 1'b0;
              tx_q      <= bank_q[ptr_q][6:0];
              sda_oe_q  <= ~bank_q[ptr_q][7];
              bit_cnt_q <= 3'd7;
              state_q   <= S_RD_BYTE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Flatten the bank onto the reg_q bus, byte i at [8*i+7:8*i].
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
    assign reg_q[8*gi +: 8] = bank_q[gi];
  end

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign wr_valid = wr_valid_q;
  assign wr_idx   = wr_idx_q;
  assign addr_hit = addr_hit_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Bench for i2c_slave_regbank: a bit-banged I2C master drives the bus and
// a byte-level model (bank array + pointer) predicts ACKs, read data,
// bank contents and the write-index sequence.
module tb_i2c_slave_regbank;
  localparam int NUM_REGS = 5;
  localparam int Q        = 8;   // clk cycles per quarter scl period

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic m_oe = 1'b0;
  wire  sda;
  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

  logic [8*NUM_REGS-1:0] reg_q;
  logic                  wr_valid, addr_hit, busy;
  logic [3:0]            wr_idx;

  i2c_slave_regbank #(.SLAVE_ADDR(7'h50), .NUM_REGS(NUM_REGS), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda), .reg_q(reg_q),
    .wr_valid(wr_valid), .wr_idx(wr_idx), .addr_hit(addr_hit), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mbank [NUM_REGS];
  int         mptr;
  int         exp_hit = 0;
  int         hit_cnt = 0;
  int         idx_q[$];
  int         exp_idx_q[$];
  logic [7:0] wq[$];

  always @(negedge clk) begin
    if (wr_valid) idx_q.push_back(int'(wr_idx));
    if (addr_hit) hit_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_regs();
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < NUM_REGS; i++) r[8*i +: 8] = mbank[i];
    return r;
  endfunction

  task automatic q_wait();
    repeat (Q) @(negedge clk);
  endtask

  // Works from idle and as a repeated START (scl low on entry).
  task automatic bus_start();
    m_oe = 1'b0; q_wait();
    scl  = 1'b1; q_wait();
    m_oe = 1'b1; q_wait();
    scl  = 1'b0; q_wait();
  endtask

  task automatic bus_stop();
    m_oe = 1'b1; q_wait();
    scl  = 1'b1; q_wait();
    m_oe = 1'b0; q_wait();
  endtask

  task automatic clk_bit(input logic b, output logic s);
    m_oe = ~b; q_wait();
    scl  = 1'b1; q_wait();
    s    = sda; q_wait();
    scl  = 1'b0; q_wait();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(1'b1, d[i]);
    clk_bit(~master_ack, s);
  endtask

  task automatic check_state(input string tag);
    int n;
    chk({tag, "_reg_q"}, 64'(reg_q), model_regs());
    chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
    chk({tag, "_sda_released"}, 64'(sda), 64'd1);
    chk({tag, "_addr_hits"}, 64'(hit_cnt), 64'(exp_hit));
    chk({tag, "_wr_count"}, 64'(idx_q.size()), 64'(exp_idx_q.size()));
    n = (idx_q.size() < exp_idx_q.size()) ? idx_q.size() : exp_idx_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_wr_idx"}, 64'(idx_q[i]), 64'(exp_idx_q[i]));
    idx_q.delete();
    exp_idx_q.delete();
  endtask

  task automatic txn_write(input string tag, input logic [6:0] a);
    logic ack;
    logic match;
    match = (a == 7'h50);
    bus_start();
    chk({tag, "_busy_start"}, 64'(busy), 64'd1);
    write_byte({a, 1'b0}, ack);
    chk({tag, "_addr_ack"}, 64'(ack), 64'(match));
    if (match) exp_hit++;
    else chk({tag, "_busy_miss"}, 64'(busy), 64'd0);
    mptr = 0;
    foreach (wq[i]) begin
      write_byte(wq[i], ack);
      chk({tag, "_data_ack"}, 64'(ack), 64'(match));
      if (match) begin
        mbank[mptr] = wq[i];
        exp_idx_q.push_back(mptr);
        mptr = (mptr + 1) % NUM_REGS;
      end
    end
    bus_stop();
    $display("txn %s: write addr=%h bytes=%0d", tag, a, wq.size());
    check_state(tag);
  endtask

  task automatic txn_read(input string tag, input int n);
    logic ack;
    logic [7:0] d;
    bus_start();
    write_byte({7'h50, 1'b1}, ack);
    chk({tag, "_addr_ack"}, 64'(ack), 64'd1);
    exp_hit++;
    mptr = 0;
    for (int i = 0; i < n; i++) begin
      read_byte(i < n - 1, d);
      chk({tag, "_rd_data"}, 64'(d), 64'(mbank[mptr]));
      if (i < n - 1) mptr = (mptr + 1) % NUM_REGS;
    end
    chk({tag, "_sda_after_nack"}, 64'(sda), 64'd1);
    chk({tag, "_busy_after_nack"}, 64'(busy), 64'd0);
    bus_stop();
    $display("txn %s: read bytes=%0d", tag, n);
    check_state(tag);
  endtask

  initial begin
    logic ack;
    logic s;
    logic [7:0] d;
    logic [6:0] a;
    int kind;
    int n;

    for (int i = 0; i < NUM_REGS; i++) mbank[i] = 8'h00;

    // Reset state
    repeat (10) @(posedge clk);
    #1;
    chk("rst_reg_q", 64'(reg_q), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_addr_hit", 64'(addr_hit), 64'd0);
    chk("rst_sda", 64'(sda), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    q_wait();

    // Directed write of two bytes
    wq = '{8'h11, 8'h22};
    txn_write("write2", 7'h50);
    chk("write2_byte0", 64'(reg_q[7:0]), 64'h11);
    chk("write2_byte1", 64'(reg_q[15:8]), 64'h22);

    // Read them back: ACK then NACK
    txn_read("read2", 2);

    // Wrong address (0xA4 on the wire)
    wq = '{8'h55};
    txn_write("wrong_addr", 7'h52);

    // Repeated START: write 0x33, Sr, read one byte
    bus_start();
    write_byte(8'hA0, ack);
    chk("sr_addr_ack", 64'(ack), 64'd1);
    exp_hit++;
    write_byte(8'h33, ack);
    chk("sr_data_ack", 64'(ack), 64'd1);
    mbank[0] = 8'h33;
    exp_idx_q.push_back(0);
    bus_start();
    write_byte(8'hA1, ack);
    chk("sr_rd_addr_ack", 64'(ack), 64'd1);
    exp_hit++;
    read_byte(1'b0, d);
    chk("sr_rd_data", 64'(d), 64'h33);
    bus_stop();
    $display("txn repeated_start: write 0x33, read back");
    check_state("repeated_start");

    // Pointer wrap: six bytes into a five-byte bank
    wq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    txn_write("wrap", 7'h50);
    chk("wrap_bank0", 64'(reg_q[7:0]), 64'h06);
    chk("wrap_bank4", 64'(reg_q[39:32]), 64'h05);

    // Randomized traffic against the model
    for (int t = 0; t < 8; t++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        wq.delete();
        n = $urandom_range(1, 7);
        for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
        txn_write("rand_write", 7'h50);
      end else if (kind == 1) begin
        txn_read("rand_read", $urandom_range(1, 6));
      end else begin
        a = 7'($urandom_range(0, 127));
        if (a == 7'h50) a = 7'h51;
        wq = '{8'($urandom)};
        txn_write("rand_miss", a);
      end
    end

    // Make sure the bank is non-zero before the mid-transfer reset
    wq = '{8'hA5, 8'h5A};
    txn_write("pre_rst", 7'h50);

    // Reset during the 4th data bit of a write
    bus_start();
    write_byte(8'hA0, ack);
    chk("rstmid_addr_ack", 64'(ack), 64'd1);
    exp_hit++;
    for (int i = 0; i < 3; i++) clk_bit(1'b1, s);
    m_oe = 1'b0; q_wait();
    scl  = 1'b1; q_wait();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid_sda", 64'(sda), 64'd1);
    chk("rstmid_reg_q", 64'(reg_q), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) mbank[i] = 8'h00;
    q_wait();
    scl = 1'b0; q_wait();
    for (int i = 0; i < 4; i++) clk_bit(1'b1, s);
    clk_bit(1'b1, s);
    chk("rstmid_no_ack", 64'(s), 64'd1);
    bus_stop();
    write_byte(8'hA0, ack);
    chk("rstmid_no_start_ack", 64'(ack), 64'd0);
    bus_stop();
    $display("txn rst_mid_write: reset during data bit 4");
    check_state("rst_mid_write");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
